ram_dma_engine: RTL and testbench
=================================

# ram_dma_engine

Bus-master engine that drives one port of the 64 KB dual-port block RAM as an initiator, performing byte-block copy or fill operations without CPU involvement. It owns port B of the RAM, while the CPU keeps port A. A single start pulse launches an operation, and `busy`/`done` report progress to the system controller. The RAM port it drives has one-cycle registered read latency and write-first behaviour, and this block is built around that contract.

## Interface
- `DATA_WIDTH`, 8, RAM word width.
- `ADDR_WIDTH`, 16, RAM address width; all address arithmetic is modulo 2^ADDR_WIDTH.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; latched on accepted start.
- `src_addr`  in  ADDR_WIDTH  copy source base; latched on start, ignored in fill.
- `dst_addr`  in  ADDR_WIDTH  destination base; latched on start.
- `length`  in  ADDR_WIDTH  byte count; 0 means no transfer.
- `fill_value`  in  DATA_WIDTH  fill byte; latched on start.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle completion pulse.
- `ram_we`  out  1  RAM write enable (port B).
- `ram_addr`  out  ADDR_WIDTH  RAM address (port B).
- `ram_di`  out  DATA_WIDTH  RAM write data (port B).
- `ram_do`  in  DATA_WIDTH  RAM read data (port B), valid the cycle after the address is presented with `ram_we`=0.

## Operation
- States: IDLE, READ, WRITE, FILL, FINISH.
- In IDLE, `start`=1 latches `mode`, addresses, `length` and `fill_value`:
  - If `length`=0, the next state is FINISH.
  - Otherwise, copy mode goes to READ and fill mode goes to FILL.
- READ:
  - Drives `ram_addr`=src pointer and `ram_we`=0.
  - Always goes to WRITE.
- WRITE:
  - Drives `ram_addr`=dst pointer, `ram_we`=1 and `ram_di`=`ram_do` (combinational pass-through of the registered RAM output).
  - Then increments both pointers and decrements the remaining count.
  - Goes to FINISH if the count reaches 0, else back to READ.
- FILL:
  - Drives `ram_addr`=dst pointer, `ram_we`=1 and `ram_di`=latched `fill_value`.
  - Then increments the dst pointer and decrements the count.
  - Goes to FINISH on 0, else stays in FILL.
- FINISH: `done`=1 for exactly one cycle, then the next state is IDLE.
- Copy is strictly ascending and byte-sequential:
  - With overlapping ranges where dst > src, already-written bytes are re-read; this is defined behaviour, not an error.
- Pointers wrap from 2^ADDR_WIDTH−1 to 0 without any flag.
- `start` asserted while not in IDLE (including FINISH) is ignored and not queued.
- Input changes after the accepting edge have no effect on the running operation.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `ram_we`=0, `ram_addr`=0, `ram_di`=0.
  - Internal pointers and count are 0.
- Reset mid-operation:
  - `ram_we` drops asynchronously.
  - At most the byte in its WRITE/FILL cycle is partially committed.
  - No `done` pulse is produced.
- `busy`=1 in READ, WRITE and FILL; 0 in IDLE and FINISH.
- Copy of N bytes (start accepted at edge T0):
  - `busy` rises after T0.
  - 2N cycles of READ/WRITE, then FINISH.
  - `done` is high in cycle 2N+1 after T0.
- Fill of N bytes: N FILL cycles, with `done` in cycle N+1.
- `length`=0: `done` is high in the cycle after T0, `busy` never rises, and no write occurs.
- In IDLE and FINISH, `ram_we`=0. `ram_addr`/`ram_di` hold their last values and are don't-care.
- A new `start` is accepted in the cycle after `done` at the earliest.

## Structure
- Shared package `ram_dma_pkg` holds:
  - State encoding constants (IDLE, READ, WRITE, FILL, FINISH).
  - Mode constants (`MODE_COPY`=0, `MODE_FILL`=1).
- Single flat module.
  - Pointer/count logic is small enough that no sub-module is warranted.
- The bench instantiates the existing 64 KB dual-port RAM with this block on port B, and CPU-model stimulus on port A.

## Test plan
- Fill: RAM preloaded with 0x00; fill dst=0x1000, length=4, value 0xA5 → 0x1000–0x1003 = 0xA5, 0x0FFF and 0x1004 stay 0x00, `done` 5 cycles after start.
- Copy: preload 0x2000–0x2002 = 11,22,33; copy src=0x2000, dst=0x3000, length=3 → 0x3000–0x3002 = 11,22,33, `done` 7 cycles after start, `busy` high exactly 6 cycles.
- Wrap: copy src=0xFFFE, dst=0x0010, length=4 with 0xFFFE,0xFFFF,0x0000,0x0001 = 1,2,3,4 → 0x0010–0x0013 = 1,2,3,4.
- Zero length: start with length=0 → `done` next cycle, `busy` stays 0, `ram_we` never 1.
- Overlap and ignore: copy src=0x4000, dst=0x4001, length=3 with 0x4000 = 0x7E → 0x4001–0x4003 all 0x7E; a second `start` pulsed mid-copy causes no extra writes.
- Reset mid-fill: assert `rst` during the 3rd FILL cycle of a length=8 fill → `ram_we`/`busy` drop immediately, no `done`, at most 3 bytes written, next start operates normally.

Source files
------------

// File: rtl/ram_dma_pkg.sv
// rtl/ram_dma_pkg.sv - shared state and mode encodings for the RAM DMA engine
package ram_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_FILL   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_engine_if.sv
// rtl/ram_dma_engine_if.sv - control handshake and RAM port B bundle for the DMA engine
interface ram_dma_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);

  logic                  start;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [ADDR_WIDTH-1:0] length;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  busy;
  logic                  done;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_di;
  logic [DATA_WIDTH-1:0] ram_do;

  // The engine is the bus master towards the RAM port.
  modport master (
    input  start, mode, src_addr, dst_addr, length, fill_value, ram_do,
    output busy, done, ram_we, ram_addr, ram_di
  );

  modport slave (
    output start, mode, src_addr, dst_addr, length, fill_value, ram_do,
    input  busy, done, ram_we, ram_addr, ram_di
  );

endinterface

// File: rtl/ram_dma_engine.sv
// rtl/ram_dma_engine.sv - byte copy/fill engine driving port B of the dual-port RAM
module ram_dma_engine
  import ram_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  ram_dma_engine_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_di_q, ram_di_d;

  // Outputs are computed for the state being entered so they leave the flops aligned.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          src_d = bus.src_addr;
          dst_d = bus.dst_addr;
          cnt_d = bus.length;
          if (bus.length == '0) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else if (bus.mode == MODE_FILL) begin
            state_d    = ST_FILL;
            busy_d     = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = bus.dst_addr;
            ram_di_d   = bus.fill_value;
          end else begin
            state_d    = ST_READ;
            busy_d     = 1'b1;
            ram_addr_d = bus.src_addr;
          end
        end
      end
      ST_READ: begin
        state_d    = ST_WRITE;
        busy_d     = 1'b1;
        ram_we_d   = 1'b1;
        ram_addr_d = dst_q;
      end
      ST_WRITE: begin
        src_d    = src_q + ONE;
        dst_d    = dst_q + ONE;
        cnt_d    = cnt_q - ONE;
        ram_di_d = bus.ram_do;
        if (cnt_q == ONE) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_READ;
          busy_d     = 1'b1;
          ram_addr_d = src_q + ONE;
        end
      end
      ST_FILL: begin
        dst_d = dst_q + ONE;
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          busy_d     = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = dst_q + ONE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  // Copy data bypasses the engine's flops: the RAM output register already provides the stage.
  assign bus.ram_di   = (state_q == ST_WRITE) ? bus.ram_do : ram_di_q;

endmodule

// File: tb/tb_ram_dma_engine.sv
// tb/tb_ram_dma_engine.sv - directed bench for ram_dma_engine on port B of a 64 KB dual-port RAM
module tb_ram_dma_engine;
  import ram_dma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_dma_engine_if bus ();
  ram_dma_engine dut (.clk(clk), .rst(rst), .bus(bus));

  // Dual-port RAM: port A is the CPU model, port B belongs to the engine.
  logic        a_we   = 1'b0;
  logic [15:0] a_addr = 16'h0;
  logic [7:0]  a_di   = 8'h0;
  logic [7:0]  mem [0:65535] = '{default: 8'h00};
  logic [7:0]  do_q = 8'h00;
  assign bus.ram_do = do_q;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_di;
      do_q              <= bus.ram_di;
    end else begin
      do_q <= mem[bus.ram_addr];
    end
    if (a_we) mem[a_addr] <= a_di;
  end

  int n_cmp = 0;
  int n_err = 0;
  int done_cyc, busy_cnt, we_cnt, post_cnt;

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    a_we = 1'b1; a_addr = a; a_di = d;
    @(negedge clk);
    a_we = 1'b0;
  endtask

  task automatic run_op(input logic m, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] len, input logic [7:0] fv, input int restart_at,
                        output int dc, output int bc, output int wc, output int pc);
    dc = 0; bc = 0; wc = 0; pc = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.src_addr = s; bus.dst_addr = d;
    bus.length = len; bus.fill_value = fv;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.mode = ~m; bus.src_addr = 16'hBEEF; bus.dst_addr = 16'hDEAD;
    bus.length = 16'h0077; bus.fill_value = 8'h99;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.ram_we) wc++;
      bus.start = (k == restart_at);
      if (bus.done) begin
        dc = k;
        break;
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy || bus.ram_we || bus.done) pc++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.mode = MODE_COPY; bus.src_addr = 16'h0; bus.dst_addr = 16'h0;
    bus.length = 16'h0; bus.fill_value = 8'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if (bus.busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", bus.busy); n_err++; end
    n_cmp++;
    if (bus.done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", bus.done); n_err++; end
    n_cmp++;
    if (bus.ram_we !== 1'b0) begin $display("FAIL reset_we: got %b want 0", bus.ram_we); n_err++; end
    n_cmp++;
    if (bus.ram_addr !== 16'h0) begin $display("FAIL reset_addr: got %h want 0000", bus.ram_addr); n_err++; end
    n_cmp++;
    if (bus.ram_di !== 8'h0) begin $display("FAIL reset_di: got %h want 00", bus.ram_di); n_err++; end
    n_cmp++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    run_op(MODE_FILL, 16'h0, 16'h1000, 16'd4, 8'hA5, 0, done_cyc, busy_cnt, we_cnt, post_cnt);
    if (done_cyc !== 5) begin $display("FAIL fill_done_cycle: got %0d want 5", done_cyc); n_err++; end
    n_cmp++;
    if (busy_cnt !== 4) begin $display("FAIL fill_busy_cycles: got %0d want 4", busy_cnt); n_err++; end
    n_cmp++;
    if (we_cnt !== 4) begin $display("FAIL fill_write_cycles: got %0d want 4", we_cnt); n_err++; end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      if (mem[16'h1000 + i] !== 8'hA5) begin
        $display("FAIL fill_data[%0d]: got %h want a5", i, mem[16'h1000 + i]); n_err++;
      end
      n_cmp++;
    end
    if (mem[16'h0FFF] !== 8'h00) begin $display("FAIL fill_below: got %h want 00", mem[16'h0FFF]); n_err++; end
    n_cmp++;
    if (mem[16'h1004] !== 8'h00) begin $display("FAIL fill_above: got %h want 00", mem[16'h1004]); n_err++; end
    n_cmp++;
  endtask

  task automatic test_copy();
    logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) cpu_write(16'h2000 + 16'(i), exp[i]);
    // A start pulse during FINISH must be dropped.
    run_op(MODE_COPY, 16'h2000, 16'h3000, 16'd3, 8'h00, 7, done_cyc, busy_cnt, we_cnt, post_cnt);
    if (done_cyc !== 7) begin $display("FAIL copy_done_cycle: got %0d want 7", done_cyc); n_err++; end
    n_cmp++;
    if (busy_cnt !== 6) begin $display("FAIL copy_busy_cycles: got %0d want 6", busy_cnt); n_err++; end
    n_cmp++;
    if (we_cnt !== 3) begin $display("FAIL copy_write_cycles: got %0d want 3", we_cnt); n_err++; end
    n_cmp++;
    if (post_cnt !== 0) begin $display("FAIL copy_start_in_finish: got %0d active cycles want 0", post_cnt); n_err++; end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      if (mem[16'h3000 + i] !== exp[i]) begin
        $display("FAIL copy_data[%0d]: got %h want %h", i, mem[16'h3000 + i], exp[i]); n_err++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] src [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 4; i++) cpu_write(src[i], 8'(i + 1));
    run_op(MODE_COPY, 16'hFFFE, 16'h0010, 16'd4, 8'h00, 0, done_cyc, busy_cnt, we_cnt, post_cnt);
    if (done_cyc !== 9) begin $display("FAIL wrap_done_cycle: got %0d want 9", done_cyc); n_err++; end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      if (mem[16'h0010 + i] !== 8'(i + 1)) begin
        $display("FAIL wrap_data[%0d]: got %h want %h", i, mem[16'h0010 + i], 8'(i + 1)); n_err++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_zero_length();
    run_op(MODE_FILL, 16'h0, 16'h6000, 16'd0, 8'hEE, 0, done_cyc, busy_cnt, we_cnt, post_cnt);
    if (done_cyc !== 1) begin $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); n_err++; end
    n_cmp++;
    if (busy_cnt !== 0) begin $display("FAIL zero_busy: got %0d want 0", busy_cnt); n_err++; end
    n_cmp++;
    if (we_cnt !== 0) begin $display("FAIL zero_writes: got %0d want 0", we_cnt); n_err++; end
    n_cmp++;
    if (mem[16'h6000] !== 8'h00) begin $display("FAIL zero_mem: got %h want 00", mem[16'h6000]); n_err++; end
    n_cmp++;
  endtask

  task automatic test_overlap_ignore();
    cpu_write(16'h4000, 8'h7E);
    run_op(MODE_COPY, 16'h4000, 16'h4001, 16'd3, 8'h00, 3, done_cyc, busy_cnt, we_cnt, post_cnt);
    if (done_cyc !== 7) begin $display("FAIL overlap_done_cycle: got %0d want 7", done_cyc); n_err++; end
    n_cmp++;
    if (we_cnt !== 3) begin $display("FAIL overlap_writes: got %0d want 3", we_cnt); n_err++; end
    n_cmp++;
    if (post_cnt !== 0) begin $display("FAIL overlap_restart: got %0d active cycles want 0", post_cnt); n_err++; end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      if (mem[16'h4000 + i] !== 8'h7E) begin
        $display("FAIL overlap_data[%0d]: got %h want 7e", i, mem[16'h4000 + i]); n_err++;
      end
      n_cmp++;
    end
    if (mem[16'h4004] !== 8'h00) begin $display("FAIL overlap_above: got %h want 00", mem[16'h4004]); n_err++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid_fill();
    int hits = 0;
    int dn = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = MODE_FILL; bus.dst_addr = 16'h5000;
    bus.length = 16'd8; bus.fill_value = 8'h5A;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    if (bus.busy !== 1'b1) begin $display("FAIL midfill_busy_before: got %b want 1", bus.busy); n_err++; end
    n_cmp++;
    rst = 1'b1;
    #1;
    if (bus.ram_we !== 1'b0) begin $display("FAIL midfill_we_drop: got %b want 0", bus.ram_we); n_err++; end
    n_cmp++;
    if (bus.busy !== 1'b0) begin $display("FAIL midfill_busy_drop: got %b want 0", bus.busy); n_err++; end
    n_cmp++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    if (dn !== 0) begin $display("FAIL midfill_no_done: got %0d active cycles want 0", dn); n_err++; end
    n_cmp++;
    for (int i = 0; i < 8; i++) if (mem[16'h5000 + i] === 8'h5A) hits++;
    if (hits > 3) begin $display("FAIL midfill_bytes: got %0d written want at most 3", hits); n_err++; end
    n_cmp++;
    for (int i = 3; i < 8; i++) begin
      if (mem[16'h5000 + i] !== 8'h00) begin
        $display("FAIL midfill_tail[%0d]: got %h want 00", i, mem[16'h5000 + i]); n_err++;
      end
      n_cmp++;
    end
    run_op(MODE_FILL, 16'h0, 16'h5000, 16'd2, 8'h3C, 0, done_cyc, busy_cnt, we_cnt, post_cnt);
    if (done_cyc !== 3) begin $display("FAIL after_reset_done_cycle: got %0d want 3", done_cyc); n_err++; end
    n_cmp++;
    for (int i = 0; i < 2; i++) begin
      if (mem[16'h5000 + i] !== 8'h3C) begin
        $display("FAIL after_reset_data[%0d]: got %h want 3c", i, mem[16'h5000 + i]); n_err++;
      end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_zero_length();
    test_overlap_ignore();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
